// File: rtl/iot_stream_tx_if.sv
// iot_stream_tx_if: sample-in / byte-out signal bundle of iot_stream_tx.
interface iot_stream_tx_if;
    logic         s_valid;
    logic [127:0] s_data;
    logic         s_ready;
    logic         busy;
    logic         in_en;
    logic [7:0]   iot_in;
    logic         round_done;
    logic [7:0]   word_cnt;
    logic         idle;
    modport master (output s_valid, s_data, busy, input s_ready, in_en, iot_in, round_done, word_cnt, idle);
    modport slave (input s_valid, s_data, busy, output s_ready, in_en, iot_in, round_done, word_cnt, idle);
endinterface

// File: rtl/iot_stream_tx.sv
// iot_stream_tx: buffers 128-bit samples in a FIFO and serializes them MSB byte first to the filtering core.
module iot_stream_tx #(
    parameter int DEPTH = 4,
    parameter int ROUND_LEN = 8
) (
    input logic clk,
    input logic rst,
    iot_stream_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(ROUND_LEN + 1);
    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;
    state_t state, state_n;
    logic [127:0] mem [DEPTH];
    logic [127:0] head, shift, shift_n;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt, cnt_n;
    logic s_ready, empty, push, pop;
    logic [4:0] byte_idx, byte_idx_n;
    logic in_en, in_en_n, round_done, round_done_n;
    logic [7:0] iot_in, iot_in_n, word_cnt, word_cnt_n;
    logic [RW-1:0] rnd, rnd_n;

    assign head = mem[rd_ptr];
    assign empty = cnt == '0;
    assign push = bus.s_valid && s_ready;
    assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.s_data;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_n;
            s_ready <= cnt_n != (AW+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shift <= '0;
            byte_idx <= '0;
            in_en <= 1'b0;
            iot_in <= 8'h00;
            word_cnt <= '0;
            rnd <= '0;
            round_done <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            byte_idx <= byte_idx_n;
            in_en <= in_en_n;
            iot_in <= iot_in_n;
            word_cnt <= word_cnt_n;
            rnd <= rnd_n;
            round_done <= round_done_n;
        end
    end

    // SEND and HOLD share one path: busy parks in HOLD, otherwise the next byte goes out or the sample completes
    always_comb begin
        state_n = state;
        shift_n = shift;
        byte_idx_n = byte_idx;
        in_en_n = 1'b0;
        iot_in_n = iot_in;
        word_cnt_n = word_cnt;
        rnd_n = rnd;
        round_done_n = 1'b0;
        pop = 1'b0;
        if (state != IDLE && bus.busy) begin
            state_n = HOLD;
        end else if (state != IDLE && byte_idx != 5'd16) begin
            state_n = SEND;
            in_en_n = 1'b1;
            iot_in_n = shift[127:120];
            shift_n = shift << 8;
            byte_idx_n = byte_idx + 5'd1;
        end else begin
            if (state != IDLE) begin
                word_cnt_n = word_cnt + 8'd1;
                round_done_n = rnd == RW'(ROUND_LEN - 1);
                rnd_n = round_done_n ? '0 : rnd + RW'(1);
                byte_idx_n = '0;
                state_n = IDLE;
            end
            if (!empty && !bus.busy) begin
                pop = 1'b1;
                state_n = SEND;
                in_en_n = 1'b1;
                iot_in_n = head[127:120];
                shift_n = {head[119:0], 8'h00};
                byte_idx_n = 5'd1;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.in_en = in_en;
    assign bus.iot_in = iot_in;
    assign bus.round_done = round_done;
    assign bus.word_cnt = word_cnt;
    assign bus.idle = state == IDLE && empty;
endmodule

// File: doc/iot_stream_tx.md
Name: iot_stream_tx

Overview:
- Source-side companion to the IoT data-filtering core: it serializes 128-bit sensor samples into the byte stream (in_en / iot_in) that the filtering core consumes.
- Samples are accepted on a valid/ready word interface into a small FIFO.
- Each sample is sent as 16 consecutive bytes, MSB byte first, while the core's busy input is observed.
- Completed samples are counted and a pulse is raised at each round boundary, so the bench/system can align rounds with the core's outputs.

Parameters:
- DEPTH, 4, FIFO depth in 128-bit words (power of 2, >=2).
- ROUND_LEN, 8, number of samples per processing round.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream sample valid.
- s_data  input  128  upstream sample.
- s_ready  output  1  FIFO can accept a sample (= !full, registered).
- busy  input  1  core busy flag; bytes are not issued while high.
- in_en  output  1  byte strobe to the core (registered).
- iot_in  output  8  byte to the core (registered).
- round_done  output  1  one-cycle pulse after the last byte of every ROUND_LEN-th sample.
- word_cnt  output  8  samples fully sent since reset (wraps 255->0).
- idle  output  1  high when FIFO is empty and no sample is in flight.

Behaviour:
- Reset (sync, rst=1 at an edge): FIFO emptied, FSM->IDLE, byte_idx=0, round counter=0.
  - Outputs after reset: in_en=0, iot_in=8'h00, s_ready=1, round_done=0, word_cnt=0, idle=1.
  - Reset asserted mid-sample aborts that sample; no further bytes of it are issued.
- FIFO:
  - Push when s_valid && s_ready.
  - Pop happens on sample start (head loaded into a 128-bit shift register).
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - s_ready is derived from registered occupancy, so it is low while the FIFO is full even if a pop occurs that cycle.
  - A push with s_ready=0 is ignored; the data is dropped and nothing else changes.
- FSM states: IDLE, SEND, HOLD.
  - IDLE:
    - If FIFO non-empty and busy=0: pop, go to SEND.
    - The same edge registers in_en=1, iot_in=head[127:120], byte_idx=1.
    - Otherwise in_en=0.
  - SEND, each edge:
    - If busy=1: in_en<=0, go to HOLD (byte_idx is held).
    - Else if byte_idx<16: in_en<=1, iot_in<=shift[127-8*byte_idx -: 8], byte_idx++.
    - When the 16th byte has already been issued (byte_idx=16): word_cnt++, round counter++, byte_idx<=0.
      - If the FIFO is non-empty and busy=0, the next sample starts on this same edge (pop, byte 0 issued). Back-to-back samples therefore have no gap.
      - Else go to IDLE with in_en<=0.
  - HOLD:
    - in_en=0; iot_in holds the last value.
    - When busy=0 at an edge, return to SEND and issue byte byte_idx on that edge.
- Busy latency: busy sampled at edge t controls in_en after edge t, so it takes effect one cycle later.
  - in_en is never high in the cycle following an edge at which busy=1.
- Byte sequence: exactly 16 strobes per sample, bytes B15..B0 (MSB first), with no repeats and no skips across HOLD intervals.
- round_done:
  - Pulses for one cycle on the edge where the round counter reaches ROUND_LEN; the counter then resets to 0.
  - This coincides with the word_cnt increment.
- idle = (FSM==IDLE) && FIFO empty.
- iot_in is don't-care when in_en=0, but it must hold its value rather than toggle (power).

Test Plan:
- Reset, then push one sample 128'h00112233_44556677_8899AABB_CCDDEEFF with busy=0 -> 16 consecutive in_en cycles carrying 00,11,...,FF; then in_en=0, word_cnt=1, idle=1.
- Push 8 samples back-to-back with busy=0 -> 128 contiguous in_en cycles; round_done pulses exactly once, in the cycle after the last byte; word_cnt=8.
- Raise busy for 5 cycles after the 6th byte of a sample -> in_en drops one cycle later; bytes 7..16 resume unaltered once busy falls; total strobes=16.
- Push 5 samples with busy=1 throughout -> s_ready=0 after 4 accepted; the 5th is not accepted and must be re-presented; no in_en while busy=1.
  - Then drop busy -> the four held samples are emitted in FIFO order.
- Assert rst for 1 cycle at the 9th byte of a sample -> in_en=0, word_cnt=0, s_ready=1, idle=1 on the next cycle; no remaining bytes are emitted.
- Push and pop in the same cycle with the FIFO at 2 entries -> occupancy stays 2; the sample order is preserved on the output.
